// File: rtl/ga_pkg.sv
// ga_pkg: shared types and constants for the genetic-algorithm datapath
package ga_pkg;
    localparam int CHROM_W     = 8;
    localparam int FITNESS_W   = 27;
    localparam int SEL_LATENCY = 2;
    typedef logic signed [CHROM_W-1:0]   chrom_t;
    typedef logic signed [FITNESS_W-1:0] fitness_t;
endpackage

// File: rtl/align_delay.sv
// align_delay: valid+data shift register lining up payloads with a later decision
module align_delay
    import ga_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = SEL_LATENCY
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];

    // shift every stage by one, new entry enters stage 0
    always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    // only the valid bits are cleared; data bits are don't-care while invalid
    always_ff @(posedge clk) begin
        valid_q <= reset ? valid_d : '0;
        data_q  <= data_d;
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
endmodule

// File: rtl/winner_buffer.sv
// winner_buffer: aligns chromosome pairs with selection, stores winners in a FIFO
module winner_buffer
    import ga_pkg::*;
#(
    parameter int CHROM_W = ga_pkg::CHROM_W,
    parameter int DEPTH   = 16,
    parameter int LATENCY = SEL_LATENCY
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [CHROM_W-1:0]   chrom1,
    input  logic signed [CHROM_W-1:0]   chrom2,
    input  logic                        pair_valid,
    input  logic                        selected,
    input  logic                        rd_en,
    output logic signed [CHROM_W-1:0]   rd_data,
    output logic                        rd_valid,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty,
    output logic                        gen_done,
    output logic                        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic                        v_d;
    logic [2*CHROM_W-1:0]        pair_d;
    logic signed [CHROM_W-1:0]   winner;
    logic                        push, pop;
    logic signed [CHROM_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic signed [CHROM_W-1:0]   rd_data_q, rd_data_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        gen_done_q, gen_done_d;
    logic                        overflow_q, overflow_d;

    align_delay #(.W(2*CHROM_W), .DEPTH(LATENCY)) u_align (
        .clk      (clk),
        .reset    (reset),
        .in_valid (pair_valid),
        .in_data  ({chrom1, chrom2}),
        .out_valid(v_d),
        .out_data (pair_d)
    );

    assign full   = count_q == CW'(DEPTH);
    assign empty  = count_q == '0;
    assign winner = selected ? pair_d[2*CHROM_W-1:CHROM_W] : pair_d[CHROM_W-1:0];
    assign pop    = rd_en && !empty;
    assign push   = v_d && (!full || pop);

    // next-state for pointers, occupancy, read port and status flags
    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        rd_valid_d = pop;
        rd_data_d  = pop ? mem_q[rd_ptr_q] : rd_data_q;
        gen_done_d = push && !pop && count_q == CW'(DEPTH - 1);
        overflow_d = overflow_q || (v_d && !push);
    end

    // control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            gen_done_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            gen_done_q <= gen_done_d;
            overflow_q <= overflow_d;
        end
    end

    // storage is never cleared; the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (reset && push) mem_q[wr_ptr_q] <= winner;
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign gen_done = gen_done_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_winner_buffer.sv
// tb_winner_buffer: scoreboard-driven check of winner_buffer alignment, FIFO and flags
module tb_winner_buffer;
    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic signed [7:0] chrom1 = '0, chrom2 = '0;
    logic              pair_valid = 1'b0, selected = 1'b0, rd_en = 1'b0;
    logic signed [7:0] rd_data;
    logic              rd_valid, full, empty, gen_done, overflow;
    logic [4:0]        count;

    int checks = 0;
    int failures = 0;

    logic signed [7:0] q[$];
    logic              mv[2] = '{1'b0, 1'b0};
    logic              ms[2] = '{1'b0, 1'b0};
    logic signed [7:0] mw[2] = '{8'sd0, 8'sd0};
    logic signed [7:0] last_rd = '0;

    winner_buffer #(.CHROM_W(8), .DEPTH(16), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .chrom1(chrom1), .chrom2(chrom2),
        .pair_valid(pair_valid), .selected(selected), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .full(full),
        .empty(empty), .gen_done(gen_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // one clock of stimulus; the bench plays the selection stage two cycles later
    task automatic cyc(input logic rst, input logic pv, input logic signed [7:0] c1,
                       input logic signed [7:0] c2, input logic s, input logic rd);
        logic p, pu;
        logic signed [7:0] ev;
        reset = rst; pair_valid = pv; chrom1 = c1; chrom2 = c2; rd_en = rd;
        selected = ms[1];
        p  = rd && q.size() > 0;
        pu = mv[1] && (q.size() < 16 || p);
        ev = last_rd;
        if (!rst) begin
            q.delete();
            mv = '{1'b0, 1'b0};
            p = 1'b0;
            ev = '0;
        end else begin
            if (p) ev = q.pop_front();
            if (pu) q.push_back(mw[1]);
            mv[1] = mv[0]; mw[1] = mw[0]; ms[1] = ms[0];
            mv[0] = pv; mw[0] = s ? c1 : c2; ms[0] = s;
        end
        last_rd = ev;
        @(posedge clk); #1;
        checks++;
        if (rd_valid !== p || (p && rd_data !== ev))
            begin failures++; $display("FAIL sb_pop: rd_valid=%0b rd_data=%0d expected rd_valid=%0b rd_data=%0d", rd_valid, rd_data, p, ev); end
        checks++;
        if (count !== 5'(q.size()))
            begin failures++; $display("FAIL sb_count: got %0d expected %0d", count, q.size()); end
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        checks++;
        if ({count, empty, full, rd_valid, rd_data, gen_done, overflow} !== {5'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0})
            begin failures++; $display("FAIL reset: count=%0d empty=%0b full=%0b rv=%0b rd=%0d gd=%0b ovf=%0b expected 0 1 0 0 0 0 0", count, empty, full, rd_valid, rd_data, gen_done, overflow); end
    endtask

    task automatic test_alignment();
        cyc(1, 1, 5, -3, 1, 0);
        cyc(1, 1, -7, 10, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (count !== 5'd2) begin failures++; $display("FAIL align_count: got %0d expected 2", count); end
        cyc(1, 0, 0, 0, 0, 1);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'sd5) begin failures++; $display("FAIL align_first: rv=%0b rd=%0d expected 1 5", rd_valid, rd_data); end
        cyc(1, 0, 0, 0, 0, 1);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'sd10) begin failures++; $display("FAIL align_second: rv=%0b rd=%0d expected 1 10", rd_valid, rd_data); end
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'sd10) begin failures++; $display("FAIL align_hold: rv=%0b rd=%0d expected 0 10", rd_valid, rd_data); end
    endtask

    task automatic fill(input int base);
        int gd = 0;
        int gd_cnt = -1;
        for (int i = 0; i < 18; i++) begin
            cyc(1, i < 16, 8'(base + i), -1, 1, 0);
            if (gen_done === 1'b1) begin gd++; gd_cnt = int'(count); end
        end
        checks++;
        if (gd != 1 || gd_cnt != 16 || full !== 1'b1)
            begin failures++; $display("FAIL fill: gen_done pulses=%0d at count=%0d full=%0b expected 1 16 1", gd, gd_cnt, full); end
    endtask

    task automatic test_fill();
        cyc(0, 0, 0, 0, 0, 0);
        fill(1);
        cyc(1, 1, 99, 98, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16 || gen_done !== 1'b0)
            begin failures++; $display("FAIL overflow: ovf=%0b count=%0d gd=%0b expected 1 16 0", overflow, count, gen_done); end
    endtask

    task automatic test_full_push_pop();
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %0b expected 0", overflow); end
        fill(100);
        cyc(1, 1, 77, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 8'sd100 || gen_done !== 1'b0)
            begin failures++; $display("FAIL full_pushpop: count=%0d ovf=%0b rv=%0b rd=%0d gd=%0b expected 16 0 1 100 0", count, overflow, rd_valid, rd_data, gen_done); end
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 0, 1);
        checks++;
        if (rd_data !== 8'sd77 || empty !== 1'b1)
            begin failures++; $display("FAIL full_append: last=%0d empty=%0b expected 77 1", rd_data, empty); end
    endtask

    task automatic test_empty_wrap();
        int pops = 0;
        logic signed [7:0] last = -1;
        cyc(1, 0, 0, 0, 0, 1);
        checks++;
        if (rd_valid !== 1'b0 || count !== 5'd0) begin failures++; $display("FAIL empty_pop: rv=%0b count=%0d expected 0 0", rd_valid, count); end
        for (int i = 0; i < 43; i++) begin
            cyc(1, i < 40, -5, 8'(i), 0, 1);
            if (rd_valid === 1'b1) begin pops++; last = rd_data; end
        end
        checks++;
        if (pops != 40 || last !== 8'sd39) begin failures++; $display("FAIL wrap: pops=%0d last=%0d expected 40 39", pops, last); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 11; i++) cyc(1, i < 9, 8'(i), 0, 1, 0);
        checks++;
        if (count !== 5'd9) begin failures++; $display("FAIL pre_reset: count=%0d expected 9", count); end
        cyc(1, 1, 1, 2, 1, 0);
        cyc(0, 1, 3, 4, 1, 1);
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_valid !== 1'b0)
            begin failures++; $display("FAIL mid_reset: count=%0d empty=%0b ovf=%0b rv=%0b expected 0 1 0 0", count, empty, overflow, rd_valid); end
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (count !== 5'd0) begin failures++; $display("FAIL inflight_drop: count=%0d expected 0", count); end
    endtask

    function automatic int fit(input logic signed [7:0] x);
        return 1000 - (int'(x) - 20) * (int'(x) - 20);
    endfunction

    task automatic test_chain();
        int pops = 0;
        logic signed [7:0] a, b;
        for (int i = 0; i < 2003; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            cyc(1, i < 2000, a, b, fit(a) >= fit(b), 1);
            if (rd_valid === 1'b1) pops++;
        end
        checks++;
        if (pops != 2000 || overflow !== 1'b0)
            begin failures++; $display("FAIL chain: pops=%0d ovf=%0b expected 2000 0", pops, overflow); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_alignment();
        test_fill();
        test_full_push_pop();
        test_empty_wrap();
        test_mid_reset();
        test_chain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
